rtc_access_scheduler: RTL and testbench

Sequences and arbitrates every access to the external RTC's multiplexed address/data bus. It sits between the menu FSM, the RTC interrupt line and the bus-cycle transfer engine. It merges three request sources into one stream of single-register transactions:
- a periodic time refresh (latch command plus nine register reads),
- user register writes from the menu,
- interrupt-clear writes.

Read data is forwarded, tagged with its address, to the register-image block that feeds the VGA generator.

---
 rtl/rtc_access_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_rtc_access_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_access_scheduler.sv
// Arbiter/sequencer for the RTC multiplexed bus: periodic refresh, menu writes and
// interrupt-clear writes merged into single-register transfers. IRQ path gated by RTC_SCHED_IRQ_EN.
module rtc_access_scheduler #(
  parameter int unsigned REFRESH_DIV  = 1_000_000,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [7:0]  LATCH_ADDR   = 8'hF0,
  parameter logic [7:0]  IRQ_CLR_ADDR = 8'h00,
  parameter logic [7:0]  IRQ_CLR_DATA = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       irq_n,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       irq_ack,
  output logic       xfer_start,
  output logic       xfer_wr,
  output logic [7:0] xfer_addr,
  output logic [7:0] xfer_wdata,
  input  logic       xfer_done,
  input  logic [7:0] xfer_rdata,
  output logic       rd_valid,
  output logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       err
);

  localparam int unsigned TW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {SRC_REF, SRC_WR, SRC_IRQ} src_t;

  state_t        state_q, state_d;
  src_t          src_q, src_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          refresh_pend_q, refresh_pend_d;
  logic          aborted_q, aborted_d;
  logic          err_q, err_d;
  logic          xfer_wr_q, xfer_wr_d;
  logic [7:0]    xfer_addr_q, xfer_addr_d;
  logic [7:0]    xfer_wdata_q, xfer_wdata_d;
  logic [7:0]    rd_addr_q, rd_addr_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          tick, ref_clr, irq_clr, timeout_hit;
  logic          irq_pend;

  // Refresh register map: latch command, then time regs 21..26, then 41..43.
  function automatic logic [7:0] ref_addr(input logic [3:0] idx);
    logic [7:0] a;
    if (idx == 4'd0)      a = LATCH_ADDR;
    else if (idx <= 4'd6) a = 8'h20 + {4'h0, idx};
    else                  a = 8'h3A + {4'h0, idx};
    return a;
  endfunction

`ifdef RTC_SCHED_IRQ_EN
  logic [2:0] irq_sync_q, irq_sync_d;
  logic       irq_pend_q, irq_pend_d;
  logic       irq_fall;

  always_comb begin
    irq_sync_d = {irq_sync_q[1:0], irq_n};
    irq_fall   = irq_sync_q[2] & ~irq_sync_q[1];
    irq_pend_d = irq_pend_q;
    if (irq_clr)  irq_pend_d = 1'b0;
    if (irq_fall) irq_pend_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      irq_sync_q <= '1;
      irq_pend_q <= 1'b0;
    end else begin
      irq_sync_q <= irq_sync_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_pend = irq_pend_q;
  assign irq_ack  = (state_q == ST_DONE) && (src_q == SRC_IRQ);
`else
  logic unused_irq;
  assign unused_irq = irq_n | irq_clr;
  assign irq_pend   = 1'b0;
  assign irq_ack    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    idx_d        = idx_q;
    tcnt_d       = tcnt_q;
    aborted_d    = aborted_q;
    err_d        = err_q;
    xfer_wr_d    = xfer_wr_q;
    xfer_addr_d  = xfer_addr_q;
    xfer_wdata_d = xfer_wdata_q;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    ref_clr      = 1'b0;
    irq_clr      = 1'b0;
    timeout_hit  = 1'b0;
    tick         = 1'b0;

    if (tmr_q == TW'(REFRESH_DIV - 1)) begin
      tmr_d = '0;
      tick  = 1'b1;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (irq_pend) begin
          src_d        = SRC_IRQ;
          xfer_wr_d    = 1'b1;
          xfer_addr_d  = IRQ_CLR_ADDR;
          xfer_wdata_d = IRQ_CLR_DATA;
          state_d      = ST_ISSUE;
        end else if (wr_req) begin
          src_d        = SRC_WR;
          xfer_wr_d    = 1'b1;
          xfer_addr_d  = wr_addr;
          xfer_wdata_d = wr_data;
          state_d      = ST_ISSUE;
        end else if (refresh_pend_q) begin
          src_d        = SRC_REF;
          idx_d        = '0;
          xfer_wr_d    = 1'b1;
          xfer_addr_d  = LATCH_ADDR;
          xfer_wdata_d = 8'h00;
          ref_clr      = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tcnt_d    = '0;
        aborted_d = 1'b0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (xfer_done) begin
          if (!xfer_wr_q) begin
            rd_addr_d = xfer_addr_q;
            rd_data_d = xfer_rdata;
          end
          state_d = ST_DONE;
        end else if (tcnt_q == 8'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          err_d       = 1'b1;
          aborted_d   = 1'b1;
          state_d     = ST_DONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        if (src_q == SRC_IRQ) irq_clr = 1'b1;
        // An abort anywhere in the refresh abandons the remaining reads.
        if ((src_q == SRC_REF) && (idx_q < 4'd9) && !aborted_q) begin
          idx_d       = idx_q + 4'd1;
          xfer_wr_d   = 1'b0;
          xfer_addr_d = ref_addr(idx_q + 4'd1);
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    refresh_pend_d = (refresh_pend_q & ~ref_clr) | tick;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= ST_IDLE;
      src_q          <= SRC_REF;
      idx_q          <= '0;
      tcnt_q         <= '0;
      tmr_q          <= '0;
      refresh_pend_q <= 1'b0;
      aborted_q      <= 1'b0;
      err_q          <= 1'b0;
      xfer_wr_q      <= 1'b0;
      xfer_addr_q    <= '0;
      xfer_wdata_q   <= '0;
      rd_addr_q      <= '0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      idx_q          <= idx_d;
      tcnt_q         <= tcnt_d;
      tmr_q          <= tmr_d;
      refresh_pend_q <= refresh_pend_d;
      aborted_q      <= aborted_d;
      err_q          <= err_d;
      xfer_wr_q      <= xfer_wr_d;
      xfer_addr_q    <= xfer_addr_d;
      xfer_wdata_q   <= xfer_wdata_d;
      rd_addr_q      <= rd_addr_d;
      rd_data_q      <= rd_data_d;
    end
  end

  // err rises in the cycle the timeout fires, then holds via err_q.
  assign err        = err_q | timeout_hit;
  assign xfer_start = (state_q == ST_ISSUE);
  assign busy       = (state_q != ST_IDLE);
  assign wr_ack     = (state_q == ST_DONE) && (src_q == SRC_WR);
  assign rd_valid   = (state_q == ST_DONE) && !xfer_wr_q && !aborted_q;
  assign xfer_wr    = xfer_wr_q;
  assign xfer_addr  = xfer_addr_q;
  assign xfer_wdata = xfer_wdata_q;
  assign rd_addr    = rd_addr_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Scoreboard bench for rtc_access_scheduler: expected bus events are queued by the
// stimulus and popped by a monitor whenever the DUT shows start/rd_valid/ack.
module tb_rtc_access_scheduler;

  localparam int K_XS = 0;
  localparam int K_RD = 1;
  localparam int K_WA = 2;
  localparam int K_IA = 3;

  logic       CLK, RST, irq_n, wr_req;
  logic [7:0] wr_addr, wr_data;
  logic       wr_ack, irq_ack, xfer_start, xfer_wr;
  logic [7:0] xfer_addr, xfer_wdata;
  logic       xfer_done;
  logic [7:0] xfer_rdata;
  logic       rd_valid;
  logic [7:0] rd_addr, rd_data;
  logic       busy, err;
  logic       engine_dead;

  typedef struct {
    int         kind;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  rtc_access_scheduler #(
    .REFRESH_DIV (64),
    .TIMEOUT     (10),
    .LATCH_ADDR  (8'hF0),
    .IRQ_CLR_ADDR(8'h00),
    .IRQ_CLR_DATA(8'h00)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .irq_n     (irq_n),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .irq_ack   (irq_ack),
    .xfer_start(xfer_start),
    .xfer_wr   (xfer_wr),
    .xfer_addr (xfer_addr),
    .xfer_wdata(xfer_wdata),
    .xfer_done (xfer_done),
    .xfer_rdata(xfer_rdata),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic push_ev(input int k, input logic w, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.wr = w; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_refresh();
    logic [7:0] ra [0:8];
    ra = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    push_ev(K_XS, 1'b1, 8'hF0, 8'h00);
    for (int unsigned i = 0; i < 9; i++) begin
      push_ev(K_XS, 1'b0, ra[i], 8'h00);
      push_ev(K_RD, 1'b0, ra[i], ra[i] ^ 8'hFF);
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic check_ev(input string nm, input int k, input logic w,
                          input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected event wr=%b addr=%h data=%h, expected none", nm, w, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.wr !== w || e.addr !== a || e.data !== d) begin
        bad++;
        $display("FAIL %s: got kind=%0d wr=%b addr=%h data=%h, expected kind=%0d wr=%b addr=%h data=%h",
                 nm, k, w, a, d, e.kind, e.wr, e.addr, e.data);
      end
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (xfer_start) check_ev("xfer_start", K_XS, xfer_wr, xfer_addr, xfer_wr ? xfer_wdata : 8'h00);
        if (rd_valid)   check_ev("rd_valid", K_RD, 1'b0, rd_addr, rd_data);
        if (wr_ack)     check_ev("wr_ack", K_WA, 1'b0, 8'h00, 8'h00);
        if (irq_ack)    check_ev("irq_ack", K_IA, 1'b0, 8'h00, 8'h00);
      end
    end
  end

  // Transfer engine: done 3 cycles after start, rdata = addr ^ FF.
  initial begin
    logic [7:0] a;
    xfer_done  = 1'b0;
    xfer_rdata = 8'h00;
    forever begin
      @(negedge CLK);
      if (RST && xfer_start && !engine_dead) begin
        a = xfer_addr;
        repeat (3) @(negedge CLK);
        if (RST) begin
          xfer_done  = 1'b1;
          xfer_rdata = a ^ 8'hFF;
        end
        @(negedge CLK);
        xfer_done = 1'b0;
      end
    end
  end

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: still busy/pending after %0d cycles, expected idle (pending=%0d)", nm, n, exp_q.size());
    end
  endtask

  task automatic wait_start_addr(input string nm, input logic [7:0] a, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(xfer_start && xfer_addr == a) && n < budget);
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: no xfer_start to %h within %0d cycles", nm, a, budget);
    end
  endtask

  task automatic wait_wr_ack(input string nm, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!wr_ack && n < budget);
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: no wr_ack within %0d cycles", nm, budget);
    end
    @(posedge CLK);
    #1 wr_req = 1'b0;
  endtask

  task automatic cycles_to_start(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!xfer_start && n < 300);
  endtask

  function automatic logic [63:0] all_outs();
    return {19'h0, xfer_start, busy, wr_ack, irq_ack, rd_valid, err, xfer_wr,
            xfer_addr, xfer_wdata, rd_addr, rd_data};
  endfunction

  initial begin
    int n;
    int starts, iacks;
    RST = 1'b0; irq_n = 1'b1; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    engine_dead = 1'b0;

    // Reset state and first refresh
    repeat (3) @(negedge CLK);
    check("reset_outputs", all_outs(), 64'h0);
    #1 RST = 1'b1;
    push_refresh();
    cycles_to_start(n);
    check("first_refresh_latency", 64'(n), 64'd65);
    wait_idle("refresh1", 300);
    check("refresh1_err", 64'(err), 64'h0);
    check("refresh1_rd_addr_hold", 64'(rd_addr), 64'h43);
    check("refresh1_rd_data_hold", 64'(rd_data), 64'hBC);

    // Menu write raised during refresh index 3 waits for the whole sequence
    push_refresh();
    wait_start_addr("wait_idx3", 8'h23, 300);
    push_ev(K_XS, 1'b1, 8'h22, 8'h30);
    push_ev(K_WA, 1'b0, 8'h00, 8'h00);
    wr_addr = 8'h22; wr_data = 8'h30; wr_req = 1'b1;
    wait_wr_ack("wr_during_refresh", 300);
    wait_idle("after_wr", 100);

`ifdef RTC_SCHED_IRQ_EN
    // IRQ and menu write pending together: IRQ clear wins
    push_refresh();
    wait_start_addr("wait_idx7", 8'h41, 300);
    push_ev(K_XS, 1'b1, 8'h00, 8'h00);
    push_ev(K_IA, 1'b0, 8'h00, 8'h00);
    push_ev(K_XS, 1'b1, 8'h55, 8'hA7);
    push_ev(K_WA, 1'b0, 8'h00, 8'h00);
    irq_n = 1'b0; wr_addr = 8'h55; wr_data = 8'hA7; wr_req = 1'b1;
    wait_wr_ack("irq_then_wr", 200);
    irq_n = 1'b1;
    wait_idle("after_irq", 100);
`else
    // irq_n is ignored without the IRQ feature
    push_refresh();
    wait_idle("refresh_before_irq", 300);
    starts = 0; iacks = 0;
    for (int i = 0; i < 10; i++) begin
      irq_n = (i < 4 || (i >= 7 && i < 8)) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (xfer_start) starts++;
      if (irq_ack) iacks++;
    end
    irq_n = 1'b1;
    check("irq_ignored_starts", 64'(starts), 64'h0);
    check("irq_ignored_ack", 64'(iacks), 64'h0);
`endif

    // Timeout: err 11 cycles after xfer_start, sequence abandoned
    engine_dead = 1'b1;
    push_ev(K_XS, 1'b1, 8'hF0, 8'h00);
    wait_start_addr("wait_timeout_start", 8'hF0, 300);
    for (int k = 1; k <= 13; k++) begin
      @(negedge CLK);
      if (k == 10) check("err_before_timeout", 64'(err), 64'h0);
      if (k == 11) check("err_at_timeout", 64'(err), 64'h1);
      if (k == 13) check("busy_after_abort", 64'(busy), 64'h0);
    end
    engine_dead = 1'b0;
    push_refresh();
    wait_idle("refresh_after_timeout", 300);
    check("err_sticky", 64'(err), 64'h1);
    check("refresh_after_timeout_rd_addr", 64'(rd_addr), 64'h43);

    // Asynchronous reset while waiting on the engine
    push_ev(K_XS, 1'b1, 8'hF0, 8'h00);
    wait_start_addr("wait_reset_start", 8'hF0, 300);
    @(negedge CLK);
    #1 RST = 1'b0;
    #1 check("reset_in_wait_outputs", all_outs(), 64'h0);
    repeat (3) @(negedge CLK);
    #1 RST = 1'b1;
    push_refresh();
    cycles_to_start(n);
    check("post_reset_refresh_latency", 64'(n), 64'd65);
    wait_idle("post_reset_refresh", 300);
    check("post_reset_err", 64'(err), 64'h0);
    check("post_reset_rd_data", 64'(rd_data), 64'hBC);

    repeat (5) @(negedge CLK);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
